// File: rtl/regslv_apb_bridge_pkg.sv
// Shared types and constants for the register-native to APB3 bridge.
package regslv_apb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    // Read data returned with every error response.
    localparam int unsigned RD_DATA_ERR = 0;

endpackage

// File: rtl/regslv_apb_bridge_if.sv
// Upstream register-native request/ack channel plus APB3 bus, bundled as one interface.
interface regslv_apb_bridge_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 32
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  wr_en;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  ack_vld;
    logic                  ack_rdy;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  ack_err;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;

    // master: the bridge (APB master, request responder).
    modport master (
        input  req_vld, wr_en, rd_en, addr, wr_data, ack_rdy, PRDATA, PREADY, PSLVERR,
        output req_rdy, ack_vld, rd_data, ack_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );

    // slave: the environment (request issuer and APB completer).
    modport slave (
        output req_vld, wr_en, rd_en, addr, wr_data, ack_rdy, PRDATA, PREADY, PSLVERR,
        input  req_rdy, ack_vld, rd_data, ack_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
    );
endinterface

// File: rtl/regslv_apb_bridge_tmo_cnt.sv
// ACCESS-phase wait-state counter; expired fires on the wait cycle that reaches TIMEOUT_CYCLES.
module regslv_apb_bridge_tmo_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic rstn,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned        CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0]   CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    assign expired = enable && !clear && (cnt_q == CNT_LAST);

    // NOTE: sequential state is updated only with non-blocking assignments so
    // every flop samples its pre-edge inputs regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/regslv_apb_bridge.sv
// Converts each accepted register-native request into one APB3 transfer and one ack.
module regslv_apb_bridge
    import regslv_apb_bridge_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 64,
    parameter int          DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                global_sync_reset_in,
    regslv_apb_bridge_if.master bus
);
    localparam logic [DATA_WIDTH-1:0] ERR_DATA = DATA_WIDTH'(RD_DATA_ERR);

    state_e                state_q,   state_d;
    logic [ADDR_WIDTH-1:0] addr_q,    addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,   wdata_d;
    logic                  pwrite_q,  pwrite_d;
    logic                  ack_vld_q, ack_vld_d;
    logic                  ack_err_q, ack_err_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    logic req_rdy, psel, penable;
    logic tmo_clear, tmo_enable, tmo_expired;
    logic rst_any;

    assign rst_any = !rstn || global_sync_reset_in;

    regslv_apb_bridge_tmo_cnt #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_tmo_cnt (
        .clk     (clk),
        .rstn    (rstn),
        .clear   (tmo_clear),
        .enable  (tmo_enable),
        .expired (tmo_expired)
    );

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pwrite_d   = pwrite_q;
        ack_vld_d  = ack_vld_q;
        ack_err_d  = ack_err_q;
        rd_data_d  = rd_data_q;
        req_rdy    = 1'b0;
        psel       = 1'b0;
        penable    = 1'b0;
        tmo_clear  = (state_q != ACCESS) || global_sync_reset_in;
        tmo_enable = (state_q == ACCESS) && !bus.PREADY;

        unique case (state_q)
            IDLE: begin
                req_rdy = 1'b1;
                if (bus.req_vld) begin
                    if (bus.wr_en ^ bus.rd_en) begin
                        addr_d   = bus.addr;
                        wdata_d  = bus.wr_data;
                        pwrite_d = bus.wr_en;
                        state_d  = SETUP;
                    end else begin
                        // Ambiguous direction: answer with an error, never touch APB.
                        state_d   = RESP;
                        ack_vld_d = 1'b1;
                        ack_err_d = 1'b1;
                        rd_data_d = ERR_DATA;
                    end
                end
            end
            SETUP: begin
                psel    = 1'b1;
                state_d = ACCESS;
            end
            ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
                if (bus.PREADY) begin
                    state_d   = RESP;
                    ack_vld_d = 1'b1;
                    ack_err_d = bus.PSLVERR;
                    rd_data_d = (pwrite_q || bus.PSLVERR) ? ERR_DATA : bus.PRDATA;
                end else if (tmo_expired) begin
                    state_d   = RESP;
                    ack_vld_d = 1'b1;
                    ack_err_d = 1'b1;
                    rd_data_d = ERR_DATA;
                end
            end
            RESP: begin
                if (bus.ack_rdy) begin
                    state_d   = IDLE;
                    ack_vld_d = 1'b0;
                    ack_err_d = 1'b0;
                    rd_data_d = ERR_DATA;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_any) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            pwrite_q  <= 1'b0;
            ack_vld_q <= 1'b0;
            ack_err_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            pwrite_q  <= pwrite_d;
            ack_vld_q <= ack_vld_d;
            ack_err_q <= ack_err_d;
            rd_data_q <= rd_data_d;
        end
    end

    assign bus.req_rdy = req_rdy;
    assign bus.ack_vld = ack_vld_q;
    assign bus.ack_err = ack_err_q;
    assign bus.rd_data = rd_data_q;
    assign bus.PSEL    = psel;
    assign bus.PENABLE = penable;
    assign bus.PWRITE  = pwrite_q;
    assign bus.PADDR   = addr_q;
    assign bus.PWDATA  = wdata_q;
endmodule

// File: tb/tb_regslv_apb_bridge.sv
// Self-checking bench: directed corner cases then random transactions against a latency/response model.
module tb_regslv_apb_bridge;
    localparam int AW  = 64;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic clk = 1'b0;
    logic rstn;
    logic global_sync_reset_in;

    int n_cmp = 0;
    int n_err = 0;

    regslv_apb_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    regslv_apb_bridge #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk                  (clk),
        .rstn                 (rstn),
        .global_sync_reset_in (global_sync_reset_in),
        .bus                  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Model: accept at edge 0; ack visible after edge kend, APB select held for k < kend.
    task automatic do_txn(input bit wr, input bit rd, input logic [63:0] a, input logic [31:0] wd,
                          input int waits, input bit serr, input logic [31:0] prd,
                          input int hold, input string tag);
        bit          valid;
        bit          tmo;
        int          kend;
        bit          exp_err;
        logic [31:0] exp_rd;
        valid   = wr ^ rd;
        tmo     = valid && (waits >= TMO);
        kend    = !valid ? 0 : (tmo ? 1 + TMO : 2 + waits);
        exp_err = !valid || tmo || serr;
        exp_rd  = (valid && rd && !exp_err) ? prd : 32'h0;

        check({tag, ".req_rdy_idle"}, bus.req_rdy, 1);
        bus.req_vld = 1'b1;
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.addr    = a;
        bus.wr_data = wd;
        bus.PRDATA  = prd;
        bus.PSLVERR = serr;
        bus.PREADY  = 1'b0;
        bus.ack_rdy = 1'b0;
        tick();
        bus.req_vld = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.addr    = ~a;
        bus.wr_data = ~wd;

        for (int k = 0; k <= kend; k++) begin
            if (k > 0) tick();
            check({tag, ".psel"},    bus.PSEL,    valid && (k < kend));
            check({tag, ".penable"}, bus.PENABLE, valid && (k >= 1) && (k < kend));
            check({tag, ".ack_vld"}, bus.ack_vld, k == kend);
            check({tag, ".req_rdy"}, bus.req_rdy, 0);
            if (valid && (k < kend)) begin
                check({tag, ".paddr"},  bus.PADDR,  a);
                check({tag, ".pwrite"}, bus.PWRITE, wr);
                if (wr) check({tag, ".pwdata"}, bus.PWDATA, wd);
            end
            bus.PREADY = valid && !tmo && (k + 1 == 2 + waits);
        end
        check({tag, ".ack_err"}, bus.ack_err, exp_err);
        check({tag, ".rd_data"}, bus.rd_data, exp_rd);

        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, ".hold_vld"},  bus.ack_vld, 1);
            check({tag, ".hold_err"},  bus.ack_err, exp_err);
            check({tag, ".hold_data"}, bus.rd_data, exp_rd);
            check({tag, ".hold_rdy"},  bus.req_rdy, 0);
            check({tag, ".hold_psel"}, bus.PSEL,    0);
        end

        bus.ack_rdy = 1'b1;
        tick();
        bus.ack_rdy = 1'b0;
        check({tag, ".done_vld"},  bus.ack_vld, 0);
        check({tag, ".done_rdy"},  bus.req_rdy, 1);
        check({tag, ".done_psel"}, bus.PSEL,    0);
    endtask

    // Start a write, then hit a reset while it sits in ACCESS; no ack may follow.
    task automatic abort_txn(input bit hard, input string tag);
        bus.req_vld = 1'b1;
        bus.wr_en   = 1'b1;
        bus.rd_en   = 1'b0;
        bus.addr    = 64'h40;
        bus.wr_data = 32'hCAFE_F00D;
        bus.PREADY  = 1'b0;
        tick();
        bus.req_vld = 1'b0;
        bus.wr_en   = 1'b0;
        tick();
        check({tag, ".in_access"}, bus.PENABLE, 1);
        if (hard) rstn = 1'b0;
        else      global_sync_reset_in = 1'b1;
        tick();
        rstn = 1'b1;
        global_sync_reset_in = 1'b0;
        check({tag, ".psel"},    bus.PSEL,    0);
        check({tag, ".penable"}, bus.PENABLE, 0);
        check({tag, ".ack_vld"}, bus.ack_vld, 0);
        check({tag, ".req_rdy"}, bus.req_rdy, 1);
        bus.PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check({tag, ".no_ack"},  bus.ack_vld, 0);
            check({tag, ".no_psel"}, bus.PSEL,    0);
        end
        bus.PREADY = 1'b0;
    endtask

    initial begin
        rstn                 = 1'b0;
        global_sync_reset_in = 1'b0;
        bus.req_vld = 1'b0;
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.addr    = '0;
        bus.wr_data = '0;
        bus.ack_rdy = 1'b0;
        bus.PRDATA  = '0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        repeat (2) tick();

        check("rst.req_rdy", bus.req_rdy, 1);
        check("rst.ack_vld", bus.ack_vld, 0);
        check("rst.ack_err", bus.ack_err, 0);
        check("rst.rd_data", bus.rd_data, 0);
        check("rst.psel",    bus.PSEL,    0);
        check("rst.penable", bus.PENABLE, 0);
        check("rst.pwrite",  bus.PWRITE,  0);
        check("rst.paddr",   bus.PADDR,   0);
        check("rst.pwdata",  bus.PWDATA,  0);
        rstn = 1'b1;
        tick();

        do_txn(1, 0, 64'h10, 32'h1234_5678, 0, 0, 32'h0,         0, "wr_fast");
        do_txn(0, 1, 64'h14, 32'h0,         3, 0, 32'h8765_4321, 0, "rd_wait3");
        do_txn(0, 1, 64'h18, 32'h0,         0, 1, 32'hDEAD_BEEF, 1, "rd_slverr");
        do_txn(1, 0, 64'h1C, 32'hA5A5_A5A5, 0, 1, 32'h0,         0, "wr_slverr");
        do_txn(0, 1, 64'h20, 32'h0,         TMO, 0, 32'h1111_2222, 0, "rd_timeout");
        do_txn(1, 0, 64'h24, 32'h3333_4444, TMO - 1, 0, 32'h0,   0, "wr_last_wait");
        do_txn(1, 1, 64'h28, 32'h5555_6666, 0, 0, 32'h7777_8888, 5, "inv_both");
        do_txn(0, 0, 64'h2C, 32'h0,         0, 0, 32'h9999_AAAA, 1, "inv_none");

        abort_txn(0, "soft_abort");
        do_txn(1, 0, 64'h44, 32'hBEEF_0001, 1, 0, 32'h0, 0, "after_soft");
        abort_txn(1, "hard_abort");
        do_txn(0, 1, 64'h48, 32'h0, 2, 0, 32'h0BAD_F00D, 0, "after_hard");

        for (int i = 0; i < 40; i++) begin
            int          kind;
            bit          wr, rd;
            kind = int'($urandom_range(0, 5));
            wr   = (kind <= 1) || (kind == 4);
            rd   = ((kind == 2) || (kind == 3)) || (kind == 4);
            do_txn(wr, rd, {$urandom, $urandom}, $urandom, int'($urandom_range(0, TMO + 1)),
                   ($urandom_range(0, 3) == 0), $urandom, int'($urandom_range(0, 2)),
                   $sformatf("rnd%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
